// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory port between the core and a debug/loader
// port. Round-robin arbitration with a debug lock, a one-cycle read wait state and
// a one-cycle error response for misaligned accesses.
module dmem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // core port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [2:0]        c_len,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic              c_err,
  output logic [DATA_W-1:0] c_rdata,
  // debug / loader port
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_len,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  // data memory
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_in,
  output logic [2:0]        m_len,
  output logic              m_read,
  output logic              m_write,
  output logic              m_ce,
  input  logic [DATA_W-1:0] m_out
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] ERR_RSP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_core_q;
  logic              lock_q;
  logic              owner_dbg_q;
  logic [DATA_W-1:0] c_rdata_q, d_rdata_q;

  logic              lock_active;
  logic              core_elig;
  logic              grant_core, grant_dbg, any_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_len;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_aligned;
  logic              access_ok;
  logic              rsp_active;
  logic [DATA_W-1:0] rsp_data;

  // Byte accesses are always aligned; halfwords need addr[0]=0, words addr[1:0]=0.
  function automatic logic is_aligned(input logic [2:0] len, input logic [1:0] lo);
    logic ok;
    case (len)
      3'b001, 3'b101: ok = 1'b1;
      3'b010, 3'b110: ok = ~lo[0];
      default:        ok = (lo == 2'b00);
    endcase
    return ok;
  endfunction

  // The lock only holds while the debug port keeps d_lock asserted.
  assign lock_active = lock_q & d_lock;
  assign core_elig   = c_req & ~lock_active;

  // Grant selection: only in IDLE and out of reset; round-robin on contention.
  always_comb begin
    grant_core = 1'b0;
    grant_dbg  = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (core_elig && d_req) begin
        if (last_core_q) grant_dbg  = 1'b1;
        else             grant_core = 1'b1;
      end else if (core_elig) begin
        grant_core = 1'b1;
      end else if (d_req) begin
        grant_dbg = 1'b1;
      end
    end
  end

  assign any_gnt   = grant_core | grant_dbg;
  assign sel_addr  = grant_dbg ? d_addr  : c_addr;
  assign sel_len   = grant_dbg ? d_len   : c_len;
  assign sel_we    = grant_dbg ? d_we    : c_we;
  assign sel_wdata = grant_dbg ? d_wdata : c_wdata;

  assign sel_aligned = is_aligned(sel_len, sel_addr[1:0]);
  assign access_ok   = any_gnt & sel_aligned;

  assign c_gnt   = grant_core;
  assign d_gnt   = grant_dbg;
  assign c_stall = c_req & ~grant_core;

  assign m_ce    = access_ok;
  assign m_write = access_ok & sel_we;
  assign m_read  = access_ok & ~sel_we;
  assign m_addr  = access_ok ? sel_addr  : '0;
  assign m_in    = access_ok ? sel_wdata : '0;
  assign m_len   = access_ok ? sel_len   : 3'b000;

  // Next-state: reads and misaligned accesses spend one response cycle.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (any_gnt && !sel_aligned) state_d = ERR_RSP;
        else if (any_gnt && !sel_we) state_d = RD_WAIT;
        else                         state_d = IDLE;
      end
      RD_WAIT: state_d = IDLE;
      ERR_RSP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, arbitration pointer, lock and response owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_core_q <= 1'b0;
      lock_q      <= 1'b0;
      owner_dbg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (any_gnt) begin
        last_core_q <= grant_core;
        owner_dbg_q <= grant_dbg;
      end
      lock_q <= d_lock ? (lock_q | grant_dbg) : 1'b0;
    end
  end

  assign rsp_active = (state_q == RD_WAIT) || (state_q == ERR_RSP);
  assign rsp_data   = (state_q == RD_WAIT) ? m_out : '0;

  // Hold the last response data per port until that port's next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (rsp_active) begin
      if (owner_dbg_q) d_rdata_q <= rsp_data;
      else             c_rdata_q <= rsp_data;
    end
  end

  assign c_rvalid = rsp_active & ~owner_dbg_q;
  assign d_rvalid = rsp_active &  owner_dbg_q;
  assign c_err    = (state_q == ERR_RSP) & ~owner_dbg_q;
  assign d_err    = (state_q == ERR_RSP) &  owner_dbg_q;
  assign c_rdata  = c_rvalid ? rsp_data : c_rdata_q;
  assign d_rdata  = d_rvalid ? rsp_data : d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for dmem_arbiter with a small word memory
// model answering reads one cycle after issue.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c_req, c_we, c_gnt, c_stall, c_rvalid, c_err;
  logic [4:0]  c_addr;
  logic [2:0]  c_len;
  logic [31:0] c_wdata, c_rdata;
  logic        d_req, d_we, d_lock, d_gnt, d_rvalid, d_err;
  logic [4:0]  d_addr;
  logic [2:0]  d_len;
  logic [31:0] d_wdata, d_rdata;
  logic [4:0]  m_addr;
  logic [31:0] m_in, m_out;
  logic [2:0]  m_len;
  logic        m_read, m_write, m_ce;

  logic [31:0] mem [0:7];

  int vectors;
  int miscompares;

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_len(c_len), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_err(c_err), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_len(d_len),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_in(m_in), .m_len(m_len), .m_read(m_read), .m_write(m_write),
    .m_ce(m_ce), .m_out(m_out)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word memory: writes land at the edge, read data appears the next cycle.
  always @(posedge clk) begin
    if (m_ce && m_write) mem[m_addr[4:2]] <= m_in;
    if (m_ce && m_read)  m_out <= mem[m_addr[4:2]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then let combinational logic settle.
  task automatic applyStimulus(
    input logic rn,
    input logic cr, input logic cw, input logic [4:0] ca, input logic [2:0] cl, input logic [31:0] cd,
    input logic dr, input logic dw, input logic dl, input logic [4:0] da, input logic [2:0] dln,
    input logic [31:0] dd);
    @(negedge clk);
    rst_n   = rn;
    c_req   = cr; c_we = cw; c_addr = ca; c_len = cl; c_wdata = cd;
    d_req   = dr; d_we = dw; d_lock = dl; d_addr = da; d_len = dln; d_wdata = dd;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_out       = 32'h0;
    rst_n = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_len = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = 0; d_len = 0; d_wdata = 0;
    #1 rst_n = 1'b0;

    // Reset: requests are ignored while rst_n is low
    applyStimulus(0, 1,1,5'h04,3'b000,32'h1234_5678, 1,1,0,5'h08,3'b000,32'h0);
    checkOutput("rst_c_gnt",    {31'b0, c_gnt},    32'h0);
    checkOutput("rst_d_gnt",    {31'b0, d_gnt},    32'h0);
    checkOutput("rst_m_ce",     {31'b0, m_ce},     32'h0);
    checkOutput("rst_c_rvalid", {31'b0, c_rvalid}, 32'h0);
    checkOutput("rst_c_rdata",  c_rdata,           32'h0);
    checkOutput("rst_d_rdata",  d_rdata,           32'h0);

    // Core word write in the first cycle out of reset
    applyStimulus(1, 1,1,5'h04,3'b000,32'hDEAD_BEEF, 0,0,0,5'h00,3'b000,32'h0);
    checkOutput("wr_c_gnt",   {31'b0, c_gnt},   32'h1);
    checkOutput("wr_m_write", {31'b0, m_write}, 32'h1);
    checkOutput("wr_m_addr",  {27'b0, m_addr},  32'h4);
    checkOutput("wr_m_in",    m_in,             32'hDEAD_BEEF);
    checkOutput("wr_c_stall", {31'b0, c_stall}, 32'h0);

    // Core read back
    applyStimulus(1, 1,0,5'h04,3'b000,32'h0, 0,0,0,5'h00,3'b000,32'h0);
    checkOutput("rd_c_gnt",  {31'b0, c_gnt},  32'h1);
    checkOutput("rd_m_read", {31'b0, m_read}, 32'h1);
    applyStimulus(1, 0,0,5'h00,3'b000,32'h0, 0,0,0,5'h00,3'b000,32'h0);
    checkOutput("rd_c_rvalid", {31'b0, c_rvalid}, 32'h1);
    checkOutput("rd_c_rdata",  c_rdata,           32'hDEAD_BEEF);
    checkOutput("rd_c_err",    {31'b0, c_err},    32'h0);

    // Debug writes preload two words; core rdata must stay held
    applyStimulus(1, 0,0,5'h00,3'b000,32'h0, 1,1,0,5'h08,3'b000,32'h1111_2222);
    checkOutput("dw1_d_gnt",   {31'b0, d_gnt},    32'h1);
    checkOutput("dw1_c_rvalid",{31'b0, c_rvalid}, 32'h0);
    checkOutput("dw1_c_rdata", c_rdata,           32'hDEAD_BEEF);
    applyStimulus(1, 0,0,5'h00,3'b000,32'h0, 1,1,0,5'h0C,3'b000,32'h3333_4444);
    checkOutput("dw2_d_gnt", {31'b0, d_gnt}, 32'h1);

    // Round-robin reads with both ports requesting continuously
    applyStimulus(1, 1,0,5'h08,3'b000,32'h0, 1,0,0,5'h0C,3'b000,32'h0);
    checkOutput("rr1_c_gnt",  {31'b0, c_gnt},  32'h1);
    checkOutput("rr1_d_gnt",  {31'b0, d_gnt},  32'h0);
    checkOutput("rr1_m_addr", {27'b0, m_addr}, 32'h8);
    applyStimulus(1, 1,0,5'h08,3'b000,32'h0, 1,0,0,5'h0C,3'b000,32'h0);
    checkOutput("rr1w_gnts",    {30'b0, c_gnt, d_gnt}, 32'h0);
    checkOutput("rr1w_c_stall", {31'b0, c_stall},      32'h1);
    checkOutput("rr1w_c_rdata", c_rdata,               32'h1111_2222);
    applyStimulus(1, 1,0,5'h08,3'b000,32'h0, 1,0,0,5'h0C,3'b000,32'h0);
    checkOutput("rr2_d_gnt",   {31'b0, d_gnt},   32'h1);
    checkOutput("rr2_c_stall", {31'b0, c_stall}, 32'h1);
    checkOutput("rr2_m_addr",  {27'b0, m_addr},  32'hC);
    applyStimulus(1, 1,0,5'h08,3'b000,32'h0, 1,0,0,5'h0C,3'b000,32'h0);
    checkOutput("rr2w_d_rvalid", {31'b0, d_rvalid}, 32'h1);
    checkOutput("rr2w_c_rvalid", {31'b0, c_rvalid}, 32'h0);
    checkOutput("rr2w_d_rdata",  d_rdata,           32'h3333_4444);
    applyStimulus(1, 1,0,5'h08,3'b000,32'h0, 1,0,0,5'h0C,3'b000,32'h0);
    checkOutput("rr3_gnts", {30'b0, c_gnt, d_gnt}, 32'h2);
    applyStimulus(1, 0,0,5'h00,3'b000,32'h0, 0,0,0,5'h00,3'b000,32'h0);
    checkOutput("rr3w_c_rdata", c_rdata, 32'h1111_2222);
    checkOutput("rr3w_d_hold",  d_rdata, 32'h3333_4444);

    // Misaligned halfword read
    applyStimulus(1, 1,0,5'h03,3'b010,32'h0, 0,0,0,5'h00,3'b000,32'h0);
    checkOutput("mis_c_gnt", {31'b0, c_gnt}, 32'h1);
    checkOutput("mis_m_ce",  {31'b0, m_ce},  32'h0);
    applyStimulus(1, 0,0,5'h00,3'b000,32'h0, 0,0,0,5'h00,3'b000,32'h0);
    checkOutput("mis_rsp", {30'b0, c_rvalid, c_err}, 32'h3);
    checkOutput("mis_c_rdata", c_rdata, 32'h0);
    applyStimulus(1, 0,0,5'h00,3'b000,32'h0, 0,0,0,5'h00,3'b000,32'h0);
    checkOutput("mis_pulse", {30'b0, c_rvalid, c_err}, 32'h0);

    // Debug lock: three locked debug writes while the core keeps requesting
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1,0,5'h04,3'b000,32'h0, 1,1,1,5'h18,3'b000,32'hCAFE_0000 + i);
      checkOutput($sformatf("lock%0d_gnts", i), {30'b0, c_gnt, d_gnt}, 32'h1);
    end
    applyStimulus(1, 1,0,5'h04,3'b000,32'h0, 0,0,1,5'h00,3'b000,32'h0);
    checkOutput("lock_idle_gnts",  {30'b0, c_gnt, d_gnt}, 32'h0);
    checkOutput("lock_idle_stall", {31'b0, c_stall},      32'h1);
    applyStimulus(1, 1,0,5'h04,3'b000,32'h0, 0,0,0,5'h00,3'b000,32'h0);
    checkOutput("unlock_c_gnt", {31'b0, c_gnt}, 32'h1);
    applyStimulus(1, 0,0,5'h00,3'b000,32'h0, 0,0,0,5'h00,3'b000,32'h0);
    checkOutput("unlock_c_rdata", c_rdata, 32'hDEAD_BEEF);

    // Reset pulsed while a read waits for its response
    applyStimulus(1, 1,0,5'h08,3'b000,32'h0, 0,0,0,5'h00,3'b000,32'h0);
    checkOutput("rw_c_gnt", {31'b0, c_gnt}, 32'h1);
    applyStimulus(0, 0,0,5'h00,3'b000,32'h0, 0,0,0,5'h00,3'b000,32'h0);
    checkOutput("rw_rvalids", {30'b0, c_rvalid, d_rvalid}, 32'h0);
    checkOutput("rw_c_rdata", c_rdata, 32'h0);
    checkOutput("rw_d_rdata", d_rdata, 32'h0);
    applyStimulus(0, 0,0,5'h00,3'b000,32'h0, 0,0,0,5'h00,3'b000,32'h0);
    checkOutput("rw_hold_rvalids", {30'b0, c_rvalid, d_rvalid}, 32'h0);
    applyStimulus(1, 1,0,5'h08,3'b000,32'h0, 1,0,0,5'h0C,3'b000,32'h0);
    checkOutput("rel_rvalids", {30'b0, c_rvalid, d_rvalid}, 32'h0);
    checkOutput("rel_gnts",    {30'b0, c_gnt, d_gnt},       32'h2);
    applyStimulus(1, 0,0,5'h00,3'b000,32'h0, 0,0,0,5'h00,3'b000,32'h0);
    checkOutput("rel_c_rdata", c_rdata, 32'h1111_2222);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, byte-address width of the data memory.
REQ-002 Parameter DATA_W, default 32, data word width; fixed at 32 for byte/halfword lane rules.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 c_req, c_we  input  1 each  core access request / write (0 = read).
REQ-006 c_addr  input  ADDR_W  core byte address; c_len input 3, MemLen code (001 B, 010 H, 101 B signed, 110 H signed, other = word); c_wdata input DATA_W.
REQ-007 c_gnt  output  1  core request accepted this cycle; c_stall output 1, equal to c_req & ~c_gnt.
REQ-008 c_rvalid, c_err  output  1 each; c_rdata output DATA_W  core response.
REQ-009 d_req, d_we, d_lock  input  1 each; d_addr ADDR_W, d_len 3, d_wdata DATA_W  debug/loader port, same meaning as core.
REQ-010 d_gnt, d_rvalid, d_err  output  1 each; d_rdata output DATA_W  debug response.
REQ-011 m_addr ADDR_W, m_in DATA_W, m_len 3, m_read 1, m_write 1, m_ce 1  outputs to data memory; m_out input DATA_W, valid one cycle after a read issue.

Function
REQ-012 FSM states: IDLE, RD_WAIT, ERR_RSP.
REQ-013 In IDLE, a grant is issued combinationally in the cycle the winning requester has req=1; at most one gnt per cycle.
REQ-014 Granted aligned access drives m_addr/m_in/m_len from the winner, m_ce=1, m_write=we, m_read=~we, same cycle; all m_* control lines 0 otherwise.
REQ-015 Granted write completes at the same clock edge; FSM stays IDLE; back-to-back writes at one per cycle.
REQ-016 Granted read moves FSM to RD_WAIT, recording owner; next cycle owner's rvalid=1, rdata=m_out; no grant issued in RD_WAIT; FSM returns to IDLE.
REQ-017 Misaligned access (halfword with addr[0]=1, word with addr[1:0]!=0) is granted but m_ce=0, no memory write; FSM to ERR_RSP; next cycle owner's rvalid=1, err=1, rdata=0; return to IDLE.
REQ-018 Arbitration: single requester wins; both requesting -> round-robin, winner = port not granted last; pointer updates only on grant.
REQ-019 Lock: debug grant with d_lock=1 sets lock; while lock set, core never granted; lock clears in the first cycle d_lock=0 and remains clear.
REQ-020 Lock set with d_req=0 -> no grants; core stalls.
REQ-021 rvalid/err are single-cycle pulses; rdata held until next response for that port.
REQ-022 Requester must hold req/addr/data stable until gnt; arbiter does not buffer requests.

Reset
REQ-023 rst_n low asynchronously forces FSM=IDLE, rr pointer favours core, lock=0, all rvalid/err=0, all rdata=0; gnt and m_ce=0 while rst_n low.
REQ-024 Reset during RD_WAIT or ERR_RSP discards the pending response; no rvalid after reset release.
REQ-025 First grant possible in the first cycle rst_n=1.

Verification
REQ-026 Core write addr 0x04 word 0xDEADBEEF, then read 0x04 -> c_gnt same cycle each, c_rvalid one cycle after read grant, c_rdata=0xDEADBEEF.
REQ-027 c_req and d_req high continuously, reads -> grants alternate core, debug, core, each followed by RD_WAIT cycle; c_stall=1 on non-granted cycles.
REQ-028 Core halfword read addr 0x03 -> c_gnt=1, m_ce=0, next cycle c_rvalid=1, c_err=1, c_rdata=0.
REQ-029 Debug write with d_lock=1 for 3 cycles while c_req=1 -> c_gnt=0 throughout; after d_lock=0, core granted next free cycle.
REQ-030 rst_n pulsed low in RD_WAIT -> no c_rvalid/d_rvalid, outputs at reset values, clean grant after release.
